bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD counter, the successor to the single-digit BCD up counter. It counts up or down across DIGITS cascaded decimal digits, with count enable, synchronous parallel load, and a combinational terminal-count output for chaining counters. It also provides a registered wrap flag and a load-error flag. It is used wherever the lab designs need decimal event counting or timer values, for example a 7-segment display source.

---
 rtl/bcd_updown_counter.sv | 113 +++++++++++
 tb/tb_bcd_updown_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, terminal count for
// chaining, a registered wrap pulse and a sticky-until-next-load error flag.

module bcd_digit (
    input  logic [3:0] cur,
    input  logic       cin,
    input  logic       up,
    input  logic [3:0] ld,
    output logic [3:0] nxt,
    output logic       cout,
    output logic [3:0] ld_clean,
    output logic       ld_bad
);
    // cin/cout is a carry when counting up and a borrow when counting down.
    always_comb begin
        nxt  = cur;
        cout = 1'b0;
        if (up) begin
            cout = cin && (cur == 4'd9);
            if (cin) nxt = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
        end else begin
            cout = cin && (cur == 4'd0);
            if (cin) nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
        end
    end

    assign ld_bad   = (ld > 4'd9);
    assign ld_clean = ld_bad ? 4'd0 : ld;
endmodule

module bcd_updown_counter #(
    parameter int DIGITS  = 2,
    parameter int RST_VAL = 0
) (
    input  logic                clk,
    input  logic                rst_asyn,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] d_in,
    output logic [4*DIGITS-1:0] Q_out,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] RST_BCD = to_bcd(RST_VAL);

    logic [W-1:0]      count_q, count_d, step_val, ld_val;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] ld_bad;
    logic              wrap_q, wrap_d, load_err_q, load_err_d;

    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .cur      (count_q[4*g +: 4]),
            .cin      (carry[g]),
            .up       (up_dn),
            .ld       (d_in[4*g +: 4]),
            .nxt      (step_val[4*g +: 4]),
            .cout     (carry[g+1]),
            .ld_clean (ld_val[4*g +: 4]),
            .ld_bad   (ld_bad[g])
        );
    end

    // Ripple out of the top digit means all 9s (up) or all 0s (down).
    assign tc = en & ~load & carry[DIGITS];

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = load_err_q;
        if (load) begin
            count_d    = ld_val;
            load_err_d = |ld_bad;
        end else if (en) begin
            count_d = step_val;
            wrap_d  = carry[DIGITS];
        end
    end

    always_ff @(posedge clk or negedge rst_asyn) begin
        if (!rst_asyn) begin
            count_q    <= RST_BCD;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign Q_out    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a 2-digit instance, a 4-digit instance with a
// non-zero reset value, and a second 4-digit instance chained from its tc.

module tb_bcd_updown_counter;
    logic        clk = 1'b0;
    logic        rst_asyn = 1'b1;
    logic        en = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [7:0]  d_in = '0;
    logic [7:0]  q2;
    logic        tc2, wrap2, lerr2;
    logic        en4 = 1'b0, up4 = 1'b1, load4 = 1'b0;
    logic [15:0] d4 = '0;
    logic [15:0] q4a, q4b;
    logic        tc4a, wrap4a, lerr4a, tc4b, wrap4b, lerr4b;

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(0)) u_dut2 (
        .clk(clk), .rst_asyn(rst_asyn), .en(en), .up_dn(up_dn), .load(load),
        .d_in(d_in), .Q_out(q2), .tc(tc2), .wrap(wrap2), .load_err(lerr2));

    bcd_updown_counter #(.DIGITS(4), .RST_VAL(9998)) u_dut4a (
        .clk(clk), .rst_asyn(rst_asyn), .en(en4), .up_dn(up4), .load(load4),
        .d_in(d4), .Q_out(q4a), .tc(tc4a), .wrap(wrap4a), .load_err(lerr4a));

    bcd_updown_counter #(.DIGITS(4), .RST_VAL(0)) u_dut4b (
        .clk(clk), .rst_asyn(rst_asyn), .en(tc4a), .up_dn(1'b1), .load(1'b0),
        .d_in(16'h0000), .Q_out(q4b), .tc(tc4b), .wrap(wrap4b), .load_err(lerr4b));

    // ---------------- behavioural model (plain decimal integers) -----------
    function automatic int clean_val(input logic [31:0] d, input int nd);
        int v = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            int dig = int'(d[4*i +: 4]);
            v = v * 10 + ((dig > 9) ? 0 : dig);
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [31:0] d, input int nd);
        bit b = 1'b0;
        for (int i = 0; i < nd; i++) if (d[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] int2bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int rem = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    function automatic bit m_tc(input int m, input int mod, input logic e, input logic l, input logic u);
        return e && !l && (u ? (m == mod - 1) : (m == 0));
    endfunction

    function automatic int m_step(input int m, input int mod, input logic u);
        return u ? (m + 1) % mod : (m + mod - 1) % mod;
    endfunction

    int m2 = 0, m4a = 9998, m4b = 0;
    bit mw2 = 0, ml2 = 0, mw4a = 0, ml4a = 0, mw4b = 0;

    wire e_tc2  = m_tc(m2, 100, en, load, up_dn);
    wire e_tc4a = m_tc(m4a, 10000, en4, load4, up4);
    wire e_tc4b = m_tc(m4b, 10000, e_tc4a, 1'b0, 1'b1);

    always @(posedge clk or negedge rst_asyn) begin
        if (!rst_asyn) begin
            m2 <= 0; mw2 <= 0; ml2 <= 0;
            m4a <= 9998; mw4a <= 0; ml4a <= 0;
            m4b <= 0; mw4b <= 0;
        end else begin
            if (load) begin
                m2 <= clean_val(32'(d_in), 2); mw2 <= 0; ml2 <= has_bad(32'(d_in), 2);
            end else begin
                if (en) m2 <= m_step(m2, 100, up_dn);
                mw2 <= e_tc2;
            end
            if (load4) begin
                m4a <= clean_val(32'(d4), 4); mw4a <= 0; ml4a <= has_bad(32'(d4), 4);
            end else begin
                if (en4) m4a <= m_step(m4a, 10000, up4);
                mw4a <= e_tc4a;
            end
            if (e_tc4a) m4b <= m_step(m4b, 10000, 1'b1);
            mw4b <= e_tc4b;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: every falling edge, all outputs vs. the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("q2",     32'(q2),     int2bcd(m2, 2));
            check("tc2",    32'(tc2),    32'(e_tc2));
            check("wrap2",  32'(wrap2),  32'(mw2));
            check("lerr2",  32'(lerr2),  32'(ml2));
            check("q4a",    32'(q4a),    int2bcd(m4a, 4));
            check("tc4a",   32'(tc4a),   32'(e_tc4a));
            check("wrap4a", 32'(wrap4a), 32'(mw4a));
            check("lerr4a", 32'(lerr4a), 32'(ml4a));
            check("q4b",    32'(q4b),    int2bcd(m4b, 4));
            check("wrap4b", 32'(wrap4b), 32'(mw4b));
            check("lerr4b", 32'(lerr4b), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] pick4 [6] = '{16'h9997, 16'h0002, 16'h9999, 16'h0000, 16'h5A3F, 16'h1234};
    logic [7:0]  pick2 [4] = '{8'h99, 8'h00, 8'h98, 8'h01};

    // ---------------- stimulus with literal pins ---------------------------
    initial begin
        // 1: asynchronous reset mid-cycle, then count up through a full wrap
        @(posedge clk); #1;
        rst_asyn = 1'b0;
        #1;
        check("rst_q2",    32'(q2),    32'h00);
        check("rst_wrap2", 32'(wrap2), 32'h0);
        check("rst_lerr2", 32'(lerr2), 32'h0);
        check("rst_q4a",   32'(q4a),   32'h9998);
        check("rst_q4b",   32'(q4b),   32'h0000);
        chk_on = 1'b1;
        tick(2);
        rst_asyn = 1'b1; en = 1'b1; up_dn = 1'b1;
        tick(10);
        check("p1_q10", 32'(q2), 32'h10);
        tick(89);
        check("p1_q99",  32'(q2),  32'h99);
        check("p1_tc99", 32'(tc2), 32'h1);
        tick(1);
        check("p1_q00",   32'(q2),    32'h00);
        check("p1_wrap",  32'(wrap2), 32'h1);
        tick(1);
        check("p1_wrap0", 32'(wrap2), 32'h0);

        // 2: load 05 then count down through a borrow wrap
        load = 1'b1; d_in = 8'h05; en = 1'b0;
        tick(1);
        check("p2_ld05", 32'(q2), 32'h05);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick(5);
        check("p2_q00",  32'(q2),  32'h00);
        check("p2_tc00", 32'(tc2), 32'h1);
        tick(1);
        check("p2_q99",  32'(q2),    32'h99);
        check("p2_wrap", 32'(wrap2), 32'h1);
        tick(1);
        check("p2_q98",  32'(q2), 32'h98);

        // 3: load sanitising and load_err
        en = 1'b0; load = 1'b1; d_in = 8'h3C;
        tick(1);
        check("p3_q30",  32'(q2),    32'h30);
        check("p3_err1", 32'(lerr2), 32'h1);
        d_in = 8'h42;
        tick(1);
        check("p3_q42",  32'(q2),    32'h42);
        check("p3_err0", 32'(lerr2), 32'h0);

        // 4: load beats terminal count, then hold
        d_in = 8'h99;
        tick(1);
        en = 1'b1; up_dn = 1'b1; d_in = 8'h17;
        #1;
        check("p4_tc_ld", 32'(tc2), 32'h0);
        tick(1);
        check("p4_q17",   32'(q2),    32'h17);
        check("p4_wrap0", 32'(wrap2), 32'h0);
        load = 1'b0; en = 1'b0;
        tick(5);
        check("p4_hold", 32'(q2), 32'h17);

        // 5: direction toggling, then reset between edges
        load = 1'b1; d_in = 8'h19;
        tick(1);
        load = 1'b0; en = 1'b1;
        up_dn = 1'b1; tick(1); check("p5_a", 32'(q2), 32'h20);
        up_dn = 1'b0; tick(1); check("p5_b", 32'(q2), 32'h19);
        up_dn = 1'b1; tick(1); check("p5_c", 32'(q2), 32'h20);
        up_dn = 1'b0; tick(1); check("p5_d", 32'(q2), 32'h19);
        en = 1'b0;
        #2 rst_asyn = 1'b0;
        #1;
        check("p5_async", 32'(q2), 32'h00);
        tick(1);
        rst_asyn = 1'b1;

        // 6: 4 digits from 9998 and chaining through tc
        en4 = 1'b1; up4 = 1'b1;
        #1;
        check("p6_tc_lo", 32'(tc4a), 32'h0);
        tick(1);
        check("p6_9999", 32'(q4a),  32'h9999);
        check("p6_tc",   32'(tc4a), 32'h1);
        check("p6_b0",   32'(q4b),  32'h0000);
        tick(1);
        check("p6_0000", 32'(q4a),    32'h0000);
        check("p6_wrap", 32'(wrap4a), 32'h1);
        check("p6_b1",   32'(q4b),    32'h0001);
        en4 = 1'b0;
        tick(3);
        check("p6_bhold", 32'(q4b), 32'h0001);

        // random phase, checked entirely by the model
        for (int c = 0; c < 4000; c++) begin
            load  = ($urandom_range(9) == 0);
            en    = ($urandom_range(3) != 0);
            up_dn = 1'($urandom_range(1));
            d_in  = ($urandom_range(1) == 0) ? pick2[$urandom_range(3)] : 8'($urandom);
            load4 = ($urandom_range(7) == 0);
            en4   = ($urandom_range(3) != 0);
            up4   = 1'($urandom_range(1));
            d4    = ($urandom_range(2) == 0) ? 16'($urandom) : pick4[$urandom_range(5)];
            if ($urandom_range(499) == 0) begin
                rst_asyn = 1'b0;
                tick(1);
                rst_asyn = 1'b1;
            end
            tick(1);
        end

        chk_on = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
